// File: rtl/trng_conditioner.sv
// ---------------------------------------------------------------------------
// trng_conditioner
//
// Post-processing stage for the raw TRNG core output. Each accepted 8-bit
// sample is folded to its parity bit, debiased by a von Neumann extractor,
// and the surviving bits are packed MSB-first into bytes presented on a
// valid/ready port. A repetition-count health test watches the raw bytes
// and latches a permanent failure (cleared only by reset) when the source
// repeats the same value RCT_CUTOFF times in a row.
//
// Parameters
//   RCT_CUTOFF   consecutive identical raw samples that declare a failure
//                (legal range 2..255)
//
// Ports
//   clk          clock
//   reset        synchronous, active-high reset
//   raw_in       raw sample from the TRNG core
//   raw_valid    raw_in carries a new sample this cycle
//   enable       conditioning enable
//   out_data     conditioned byte
//   out_valid    out_data holds an unconsumed byte
//   out_ready    consumer accepts out_data this cycle
//   health_fail  sticky repetition-count failure
//   drop_count   saturating count of kept bits lost to a blocked output
// ---------------------------------------------------------------------------
module trng_conditioner #(
    parameter int unsigned RCT_CUTOFF = 32
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] raw_in,
    input  logic       raw_valid,
    input  logic       enable,
    output logic [7:0] out_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       health_fail,
    output logic [7:0] drop_count
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_FAIL = 2'd2;

    localparam logic [7:0] LP_CUTOFF = 8'(RCT_CUTOFF);

    logic [1:0] r_state;
    logic       r_pair_pending;
    logic       r_pair_bit;
    logic [6:0] r_packer;
    logic [2:0] r_bit_cnt;
    logic [7:0] r_rct_cnt;
    logic [7:0] r_prev;
    logic [7:0] r_out_data;
    logic       r_out_valid;
    logic [7:0] r_drop_count;

    logic       w_accept;
    logic       w_bit;
    logic       w_repeat;
    logic [7:0] w_rct_next;
    logic       w_trip;
    logic       w_clear;
    logic       w_keep;
    logic       w_byte_done;
    logic       w_out_free;
    logic       w_load;
    logic       w_drop;
    logic       w_xfer;
    logic [7:0] w_byte;

    assign w_accept = raw_valid && enable && (r_state == S_RUN);
    assign w_bit    = ^raw_in;

    // rct_cnt == 0 marks "no previous sample since reset/IDLE", so the first
    // sample always restarts the run at 1 regardless of r_prev.
    assign w_repeat   = (r_rct_cnt != 8'd0) && (raw_in == r_prev);
    assign w_rct_next = !w_repeat           ? 8'd1 :
                        (r_rct_cnt == 8'hFF) ? 8'hFF : r_rct_cnt + 8'd1;
    assign w_trip     = w_accept && (w_rct_next == LP_CUTOFF);

    // Leaving RUN (or sitting in IDLE) discards partial pair/packer state.
    assign w_clear = (r_state != S_FAIL) && !enable;

    // The tripping sample itself is not conditioned: pipeline is frozen.
    assign w_keep      = w_accept && !w_trip && r_pair_pending && (w_bit != r_pair_bit);
    assign w_byte_done = w_keep && (r_bit_cnt == 3'd7);
    assign w_out_free  = !r_out_valid || out_ready;
    assign w_load      = w_byte_done && w_out_free;
    assign w_drop      = w_byte_done && !w_out_free;
    assign w_xfer      = r_out_valid && out_ready;
    assign w_byte      = {r_packer, r_pair_bit};

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:  if (enable) r_state <= S_RUN;
                S_RUN: begin
                    if (w_trip)       r_state <= S_FAIL;
                    else if (!enable) r_state <= S_IDLE;
                end
                S_FAIL:  r_state <= S_FAIL;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Extractor, packer and repetition-count test
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pair_pending <= 1'b0;
            r_pair_bit     <= 1'b0;
            r_packer       <= '0;
            r_bit_cnt      <= '0;
            r_rct_cnt      <= '0;
            r_prev         <= '0;
        end else if (w_clear) begin
            r_pair_pending <= 1'b0;
            r_pair_bit     <= 1'b0;
            r_packer       <= '0;
            r_bit_cnt      <= '0;
            r_rct_cnt      <= '0;
        end else if (w_accept && !w_trip) begin
            r_rct_cnt <= w_rct_next;
            r_prev    <= raw_in;

            if (!r_pair_pending) begin
                r_pair_bit     <= w_bit;
                r_pair_pending <= 1'b1;
            end else begin
                r_pair_pending <= 1'b0;
            end

            if (w_keep) begin
                if (r_bit_cnt != 3'd7) begin
                    r_packer  <= {r_packer[5:0], r_pair_bit};
                    r_bit_cnt <= r_bit_cnt + 3'd1;
                end else if (w_load) begin
                    r_bit_cnt <= '0;
                end
                // On a blocked 8th bit the 7 packed bits are kept and
                // bit_cnt stays at 7 so the next kept bit retries the load.
            end
        end
    end

    // Output register, handshake and drop counter
    always_ff @(posedge clk) begin
        if (reset) begin
            r_out_data   <= '0;
            r_out_valid  <= 1'b0;
            r_drop_count <= '0;
        end else begin
            if (w_trip || (r_state == S_FAIL)) begin
                r_out_valid <= 1'b0;
            end else if (w_load) begin
                r_out_data  <= w_byte;
                r_out_valid <= 1'b1;
            end else if (w_xfer) begin
                r_out_valid <= 1'b0;
            end

            if (w_drop && (r_drop_count != 8'hFF)) begin
                r_drop_count <= r_drop_count + 8'd1;
            end
        end
    end

    assign out_data    = r_out_data;
    assign out_valid   = r_out_valid;
    assign health_fail = (r_state == S_FAIL);
    assign drop_count  = r_drop_count;

endmodule

// File: tb/tb_trng_conditioner.sv
// ---------------------------------------------------------------------------
// tb_trng_conditioner
//
// Directed testbench for trng_conditioner. Each scenario task drives its own
// stimulus and compares outputs against hand-computed values. Inputs change
// and outputs are sampled 1 time unit after the rising clock edge.
// ---------------------------------------------------------------------------
module tb_trng_conditioner;

    logic       clk;
    logic       reset;
    logic [7:0] raw_in;
    logic       raw_valid;
    logic       enable;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic       health_fail;
    logic [7:0] drop_count;

    int n_vec = 0;
    int n_err = 0;

    trng_conditioner #(.RCT_CUTOFF(32)) dut (
        .clk         (clk),
        .reset       (reset),
        .raw_in      (raw_in),
        .raw_valid   (raw_valid),
        .enable      (enable),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .health_fail (health_fail),
        .drop_count  (drop_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- stimulus helpers (no checking) ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        enable    = 1'b0;
        raw_valid = 1'b0;
        raw_in    = 8'h00;
        out_ready = 1'b0;
        tick();
        reset = 1'b0;
    endtask

    // IDLE -> RUN takes one edge with enable high and no sample accepted.
    task automatic do_enable();
        enable    = 1'b1;
        raw_valid = 1'b0;
        tick();
    endtask

    task automatic sample(input logic [7:0] v);
        raw_in    = v;
        raw_valid = 1'b1;
        tick();
        raw_valid = 1'b0;
    endtask

    task automatic pair(input logic [7:0] a, input logic [7:0] b);
        sample(a);
        sample(b);
    endtask

    // Each bit of val, MSB first, becomes one kept bit (16 samples total).
    task automatic feed_byte(input logic [7:0] val);
        for (int i = 7; i >= 0; i--) begin
            if (val[i]) pair(8'h01, 8'h00);
            else        pair(8'h00, 8'h01);
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        reset     = 1'b1;
        enable    = 1'b1;
        raw_valid = 1'b1;
        raw_in    = 8'h01;
        out_ready = 1'b0;
        tick();
        tick();
        n_vec++; if (out_data !== 8'h00) begin n_err++; $display("FAIL reset_data: got %h exp 00", out_data); end
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b exp 0", out_valid); end
        n_vec++; if (health_fail !== 1'b0) begin n_err++; $display("FAIL reset_health: got %b exp 0", health_fail); end
        n_vec++; if (drop_count !== 8'h00) begin n_err++; $display("FAIL reset_drop: got %h exp 00", drop_count); end
        reset     = 1'b0;
        raw_valid = 1'b0;
        enable    = 1'b0;
    endtask

    task automatic test_bias();
        do_reset();
        do_enable();
        for (int i = 0; i < 7; i++) pair(8'h01, 8'h00);
        sample(8'h01);
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL bias_early: got %b exp 0", out_valid); end
        sample(8'h00);
        n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL bias_ff_valid: got %b exp 1", out_valid); end
        n_vec++; if (out_data !== 8'hFF) begin n_err++; $display("FAIL bias_ff_data: got %h exp ff", out_data); end
        // drain FF on the first sample of the next byte
        out_ready = 1'b1;
        sample(8'h03);
        out_ready = 1'b0;
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL bias_drain: got %b exp 0", out_valid); end
        sample(8'h07);
        for (int i = 0; i < 7; i++) pair(8'h03, 8'h07);
        n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL bias_00_valid: got %b exp 1", out_valid); end
        n_vec++; if (out_data !== 8'h00) begin n_err++; $display("FAIL bias_00_data: got %h exp 00", out_data); end
    endtask

    task automatic test_discard();
        do_reset();
        do_enable();
        for (int i = 0; i < 8; i++) pair(8'h01, 8'h02);
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL discard_none: got %b exp 0", out_valid); end
        // if equal pairs had advanced bit_cnt, the byte would close early
        for (int i = 0; i < 3; i++) begin
            pair(8'h01, 8'h00);
            pair(8'h00, 8'h01);
        end
        pair(8'h01, 8'h00);
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL discard_7bits: got %b exp 0", out_valid); end
        pair(8'h00, 8'h01);
        n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL discard_aa_valid: got %b exp 1", out_valid); end
        n_vec++; if (out_data !== 8'hAA) begin n_err++; $display("FAIL discard_aa_data: got %h exp aa", out_data); end
    endtask

    task automatic test_backpressure();
        do_reset();
        do_enable();
        feed_byte(8'hFF);
        n_vec++; if (out_data !== 8'hFF) begin n_err++; $display("FAIL bp_first: got %h exp ff", out_data); end
        for (int i = 0; i < 4; i++) pair((i % 2 == 0) ? 8'h01 : 8'h00, (i % 2 == 0) ? 8'h00 : 8'h01);
        n_vec++; if (out_data !== 8'hFF) begin n_err++; $display("FAIL bp_stable: got %h exp ff", out_data); end
        n_vec++; if (drop_count !== 8'h00) begin n_err++; $display("FAIL bp_nodrop: got %h exp 00", drop_count); end
        for (int i = 0; i < 4; i++) pair((i % 2 == 0) ? 8'h01 : 8'h00, (i % 2 == 0) ? 8'h00 : 8'h01);
        n_vec++; if (drop_count !== 8'h01) begin n_err++; $display("FAIL bp_drop: got %h exp 01", drop_count); end
        n_vec++; if (out_data !== 8'hFF) begin n_err++; $display("FAIL bp_held: got %h exp ff", out_data); end
        n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL bp_held_valid: got %b exp 1", out_valid); end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL bp_release: got %b exp 0", out_valid); end
        // retained bits 1010101 plus retry bit 1
        pair(8'h01, 8'h00);
        n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL bp_retry_valid: got %b exp 1", out_valid); end
        n_vec++; if (out_data !== 8'hAB) begin n_err++; $display("FAIL bp_retry_data: got %h exp ab", out_data); end
        n_vec++; if (drop_count !== 8'h01) begin n_err++; $display("FAIL bp_drop_keep: got %h exp 01", drop_count); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] nb;
        nb = 8'h3C;
        do_reset();
        do_enable();
        feed_byte(8'hFF);
        for (int i = 7; i >= 1; i--) begin
            if (nb[i]) pair(8'h01, 8'h00);
            else       pair(8'h00, 8'h01);
            n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL b2b_hold_%0d: got %b exp 1", i, out_valid); end
        end
        sample(8'h00);
        out_ready = 1'b1;
        sample(8'h01);
        n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL b2b_valid: got %b exp 1", out_valid); end
        n_vec++; if (out_data !== 8'h3C) begin n_err++; $display("FAIL b2b_data: got %h exp 3c", out_data); end
        n_vec++; if (drop_count !== 8'h00) begin n_err++; $display("FAIL b2b_drop: got %h exp 00", drop_count); end
        tick();
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL b2b_drain: got %b exp 0", out_valid); end
        out_ready = 1'b0;
    endtask

    task automatic test_health();
        do_reset();
        do_enable();
        feed_byte(8'hFF);
        for (int i = 0; i < 31; i++) sample(8'h5A);
        n_vec++; if (health_fail !== 1'b0) begin n_err++; $display("FAIL health_31: got %b exp 0", health_fail); end
        n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL health_pending: got %b exp 1", out_valid); end
        out_ready = 1'b1;
        sample(8'h5A);
        n_vec++; if (health_fail !== 1'b1) begin n_err++; $display("FAIL health_32: got %b exp 1", health_fail); end
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL health_valid: got %b exp 0", out_valid); end
        out_ready = 1'b0;
        for (int i = 0; i < 8; i++) pair(8'h01, 8'h00);
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL health_frozen: got %b exp 0", out_valid); end
        n_vec++; if (health_fail !== 1'b1) begin n_err++; $display("FAIL health_sticky: got %b exp 1", health_fail); end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n_vec++; if (health_fail !== 1'b0) begin n_err++; $display("FAIL health_rst_fail: got %b exp 0", health_fail); end
        n_vec++; if (out_data !== 8'h00) begin n_err++; $display("FAIL health_rst_data: got %h exp 00", out_data); end
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL health_rst_valid: got %b exp 0", out_valid); end
        n_vec++; if (drop_count !== 8'h00) begin n_err++; $display("FAIL health_rst_drop: got %h exp 00", drop_count); end
        do_enable();
        feed_byte(8'hC3);
        n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL health_resume_valid: got %b exp 1", out_valid); end
        n_vec++; if (out_data !== 8'hC3) begin n_err++; $display("FAIL health_resume_data: got %h exp c3", out_data); end
    endtask

    task automatic test_enable_reset_mid();
        do_reset();
        do_enable();
        for (int i = 0; i < 5; i++) pair(8'h01, 8'h00);
        sample(8'h01);                       // leaves a pair half-filled
        enable = 1'b0;
        tick();
        do_enable();
        for (int i = 0; i < 4; i++) pair(8'h03, 8'h07);
        for (int i = 0; i < 3; i++) pair(8'h01, 8'h00);
        sample(8'h01);
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL en_early: got %b exp 0", out_valid); end
        sample(8'h00);
        n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL en_valid: got %b exp 1", out_valid); end
        n_vec++; if (out_data !== 8'h0F) begin n_err++; $display("FAIL en_data: got %h exp 0f", out_data); end

        // reset on the 3rd sample of a fresh run
        do_reset();
        do_enable();
        sample(8'h01);
        sample(8'h00);
        raw_in    = 8'h01;
        raw_valid = 1'b1;
        reset     = 1'b1;
        tick();
        reset     = 1'b0;
        raw_valid = 1'b0;
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rstmid_valid: got %b exp 0", out_valid); end
        n_vec++; if (health_fail !== 1'b0) begin n_err++; $display("FAIL rstmid_health: got %b exp 0", health_fail); end
        do_enable();
        feed_byte(8'h55);
        n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL rstmid_byte_valid: got %b exp 1", out_valid); end
        n_vec++; if (out_data !== 8'h55) begin n_err++; $display("FAIL rstmid_byte_data: got %h exp 55", out_data); end
    endtask

    initial begin
        reset     = 1'b1;
        enable    = 1'b0;
        raw_valid = 1'b0;
        raw_in    = 8'h00;
        out_ready = 1'b0;
        test_reset();
        test_bias();
        test_discard();
        test_backpressure();
        test_back_to_back();
        test_health();
        test_enable_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
